// File: rtl/rr_arbiter_8_v.sv
// Round-robin arbiter for eight requesters that share one 8:1 mux.
// The FSM walks IDLE -> GRANT -> RELEASE -> IDLE. A grant never lasts longer
// than MAX_HOLD cycles. RELEASE adds one dead cycle between two owners, and
// moves the priority pointer to the requester just after the last owner.
// Every output is a flop, so o_gnt and o_sel_code can drive the mux directly.
module rr_arbiter_8_v #(
  parameter int MAX_HOLD = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [7:0] i_req,
  output logic [7:0] o_gnt,
  output logic [2:0] o_sel_code,
  output logic       o_mux_en,
  output logic       o_busy,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Hold count value seen in the last legal GRANT cycle.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] gnt_nxt;
  logic [2:0] sel_nxt;
  logic       mux_en_nxt;
  logic       busy_nxt;
  logic       timeout_nxt;

  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;

  // Find the first active request, scanning from ptr and wrapping modulo 8.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && i_req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Compute the next state and the next value of every registered output.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    gnt_nxt     = o_gnt;
    sel_nxt     = o_sel_code;
    mux_en_nxt  = o_mux_en;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (i_en && found) begin
          state_nxt  = GRANT;
          gnt_nxt    = 8'b1 << winner;
          sel_nxt    = winner;
          mux_en_nxt = 1'b1;
          cnt_nxt    = 8'd0;
        end
      end
      GRANT: begin
        cnt_nxt = cnt + 8'd1;
        // Disable and owner drop take precedence over the hold limit.
        if (!i_en || !i_req[o_sel_code] || (cnt == HOLD_LAST)) begin
          state_nxt   = RELEASE;
          gnt_nxt     = 8'd0;
          mux_en_nxt  = 1'b0;
          ptr_nxt     = o_sel_code + 3'd1;
          timeout_nxt = i_en && i_req[o_sel_code];
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        gnt_nxt    = 8'd0;
        mux_en_nxt = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers. Reset drops the grant at once, without waiting for a clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      ptr        <= 3'd0;
      cnt        <= 8'd0;
      o_gnt      <= 8'd0;
      o_sel_code <= 3'd0;
      o_mux_en   <= 1'b0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
      o_gnt      <= gnt_nxt;
      o_sel_code <= sel_nxt;
      o_mux_en   <= mux_en_nxt;
      o_busy     <= busy_nxt;
      o_timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8_v.sv
// Testbench for rr_arbiter_8_v with MAX_HOLD = 4.
// The stimulus process pushes one expected record per grant into a queue.
// A monitor runs on the falling edge and closes a record whenever a grant ends.
// It then checks the owner, the grant length and the timeout pulse.
module tb_rr_arbiter_8_v;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel_code;
  logic       mux_en;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    int         len;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];

  rr_arbiter_8_v #(.MAX_HOLD(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_req      (req),
    .o_gnt      (gnt),
    .o_sel_code (sel_code),
    .o_mux_en   (mux_en),
    .o_busy     (busy),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] g, input logic [2:0] s, input int l, input logic t);
    exp_t e;
    e.gnt = g;
    e.sel = s;
    e.len = l;
    e.tmo = t;
    exp_q.push_back(e);
  endtask

  // Called just after a grant appears. The owner drops its request so that the
  // grant lasts h cycles. The task returns in the RELEASE cycle.
  task automatic hold_and_drop(input int h, input int owner);
    repeat (h - 1) tick();
    req[owner] = 1'b0;
    tick();
  endtask

  // Monitor: measures each grant and checks it against the next queued record.
  initial begin : monitor
    logic       prev_en;
    logic [7:0] cur_gnt;
    logic [2:0] cur_sel;
    int         cur_len;
    exp_t       e;
    prev_en = 1'b0;
    cur_gnt = 8'd0;
    cur_sel = 3'd0;
    cur_len = 0;
    forever begin
      @(negedge clk);
      if (mux_en && !prev_en) begin
        cur_gnt = gnt;
        cur_sel = sel_code;
        cur_len = 1;
      end else if (mux_en) begin
        cur_len++;
      end
      if (!mux_en && prev_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got gnt=%0h sel=%0d expected no grant", cur_gnt, cur_sel);
        end else begin
          e = exp_q.pop_front();
          chk("grant_vector", 32'(cur_gnt), 32'(e.gnt));
          chk("grant_sel", 32'(cur_sel), 32'(e.sel));
          chk("grant_len", 32'(cur_len), 32'(e.len));
          chk("grant_timeout", 32'(timeout), 32'(e.tmo));
        end
      end else begin
        chk("timeout_quiet", 32'(timeout), 32'd0);
      end
      prev_en = mux_en;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h00);
    chk("rst_sel", 32'(sel_code), 32'h0);
    chk("rst_mux_en", 32'(mux_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_gnt", 32'(gnt), 32'h00);

    // Grant appears one cycle after the request is sampled.
    en  = 1'b1;
    req = 8'h01;
    push(8'h01, 3'd0, 3, 1'b0);
    tick();
    chk("lat_gnt", 32'(gnt), 32'h01);
    chk("lat_sel", 32'(sel_code), 32'h0);
    chk("lat_mux_en", 32'(mux_en), 32'h1);
    chk("lat_busy", 32'(busy), 32'h1);
    hold_and_drop(3, 0);
    tick();

    // Requesters 0 and 7 alternate from ptr = 0; the pointer wraps 7 -> 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 8'h81;
    push(8'h01, 3'd0, 3, 1'b0);
    tick();
    hold_and_drop(3, 0);
    req = 8'h81;
    push(8'h80, 3'd7, 3, 1'b0);
    tick();
    tick();
    hold_and_drop(3, 7);
    req = 8'h81;
    push(8'h01, 3'd0, 3, 1'b0);
    tick();
    tick();
    hold_and_drop(3, 0);
    req = 8'h81;
    push(8'h80, 3'd7, 3, 1'b0);
    tick();
    tick();
    hold_and_drop(3, 7);
    req = 8'h00;
    tick();

    // Hold limit: owner 2 times out twice; the others then go ahead of it.
    req = 8'h04;
    push(8'h04, 3'd2, 4, 1'b1);
    push(8'h04, 3'd2, 4, 1'b1);
    tick();
    repeat (4) tick();
    chk("tmo_pulse", 32'(timeout), 32'h1);
    tick();
    tick();
    chk("regrant_gnt", 32'(gnt), 32'h04);
    req = 8'h0D;
    push(8'h08, 3'd3, 2, 1'b0);
    push(8'h01, 3'd0, 2, 1'b0);
    push(8'h04, 3'd2, 1, 1'b0);
    repeat (4) tick();
    tick();
    tick();
    hold_and_drop(2, 3);
    tick();
    tick();
    hold_and_drop(2, 0);
    tick();
    tick();
    hold_and_drop(1, 2);
    req = 8'h00;
    tick();

    // Disable during a grant ends it with no timeout, and blocks new grants.
    req = 8'hFF;
    push(8'h08, 3'd3, 2, 1'b0);
    tick();
    tick();
    en = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("en_low_gnt", 32'(gnt), 32'h00);
      chk("en_low_mux", 32'(mux_en), 32'h0);
    end
    en = 1'b1;
    push(8'h10, 3'd4, 1, 1'b0);
    tick();
    hold_and_drop(1, 4);
    req = 8'h00;
    tick();

    // Asynchronous reset while owner 5 holds the grant.
    req = 8'h20;
    push(8'h20, 3'd5, 1, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h00);
    chk("arst_sel", 32'(sel_code), 32'h0);
    chk("arst_mux_en", 32'(mux_en), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_timeout", 32'(timeout), 32'h0);
    req = 8'hFF;
    tick();
    rst_n = 1'b1;
    push(8'h01, 3'd0, 1, 1'b0);
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h01);
    chk("post_rst_sel", 32'(sel_code), 32'h0);
    hold_and_drop(1, 0);
    req = 8'h00;
    tick();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
